proc_trace_checker: RTL and testbench

- Hardware scoreboard directly downstream of the five-stage TinyRV1 processor's trace outputs.
- Realigns the F-stage trace address and instruction to the W stage, honouring F/D stalls.
- Compares each committed W-stage (addr, data) pair against an in-order FIFO of expected results preloaded by the bench.
- Replaces per-cycle task checks, accumulates pass/fail statistics, and captures the first failure for debug.

---
 rtl/proc_trace_checker.sv | 99 +++++++++
 tb/tb_proc_trace_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/proc_trace_checker.sv
// proc_trace_checker: realigns the TinyRV1 F-stage trace to W and scores each commit
// against an in-order FIFO of expected (addr, data) results.
module proc_trace_checker #(
  parameter int DEPTH = 32,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exp_val,
  output logic            exp_rdy,
  input  logic [31:0]     exp_addr,
  input  logic [31:0]     exp_data,
  input  logic            exp_dchk,
  input  logic            run,
  input  logic [31:0]     trace_addr,
  input  logic [31:0]     trace_inst,
  input  logic [31:0]     trace_data,
  input  logic            trace_stall,
  output logic [31:0]     addr_W,
  output logic [31:0]     inst_W,
  output logic            val_W,
  output logic [CNTW-1:0] pass_cnt,
  output logic [CNTW-1:0] fail_cnt,
  output logic [31:0]     cycles,
  output logic            err,
  output logic [31:0]     err_addr,
  output logic [31:0]     err_exp,
  output logic [31:0]     err_got,
  output logic            done
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [31:0] addr_d, inst_d, addr_x, inst_x, addr_m, inst_m;
  logic v_d, v_x, v_m;
  logic [31:0] mem_addr [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic        mem_dchk [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic empty, push, pop, pass, fail;
  assign empty   = occ == '0;
  assign exp_rdy = ~occ[AW];
  assign push    = exp_val & exp_rdy;
  assign pop     = val_W & ~empty;
  // Case equality makes any X/Z in a checked field a mismatch.
  assign pass = ~empty & (addr_W === mem_addr[rd_ptr]) &
                (~mem_dchk[rd_ptr] | (trace_data === mem_data[rd_ptr]));
  assign fail = val_W & ~pass;
  assign done = empty & ~(v_d | v_x | v_m | val_W) & ~err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {addr_d, inst_d, v_d, addr_x, inst_x, v_x} <= '0;
      {addr_m, inst_m, v_m, addr_W, inst_W, val_W} <= '0;
    end else begin
      addr_d <= trace_stall ? addr_d : trace_addr;
      inst_d <= trace_stall ? inst_d : trace_inst;
      v_d    <= trace_stall ? v_d : run;
      addr_x <= addr_d;
      inst_x <= inst_d;
      v_x    <= v_d & ~trace_stall;
      {addr_m, inst_m, v_m}    <= {addr_x, inst_x, v_x};
      {addr_W, inst_W, val_W}  <= {addr_m, inst_m, v_m};
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= exp_addr;
      mem_data[wr_ptr] <= exp_data;
      mem_dchk[wr_ptr] <= exp_dchk;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      cycles   <= '0;
      err      <= 1'b0;
      err_addr <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      occ    <= occ + OW'(push) - OW'(pop);
      cycles <= cycles + 1'b1;
      if (val_W & pass & ~&pass_cnt) pass_cnt <= pass_cnt + 1'b1;
      if (fail & ~&fail_cnt) fail_cnt <= fail_cnt + 1'b1;
      if (fail & ~err) begin
        err      <= 1'b1;
        err_addr <= addr_W;
        err_exp  <= empty ? 32'h0 : mem_data[rd_ptr];
        err_got  <= trace_data;
      end
    end
  end
endmodule

// File: tb/tb_proc_trace_checker.sv
// tb_proc_trace_checker: directed scenarios for the trace alignment and commit scoreboard.
module tb_proc_trace_checker;
  logic clk = 0, rst = 0;
  logic exp_val = 0, exp_dchk = 0, run = 0, trace_stall = 0;
  logic exp_rdy, val_W, err, done;
  logic [31:0] exp_addr = 0, exp_data = 0, trace_addr = 0, trace_inst = 0, trace_data = 0;
  logic [31:0] addr_W, inst_W, cycles, err_addr, err_exp, err_got;
  logic [15:0] pass_cnt, fail_cnt;
  int errs = 0, checks = 0;

  proc_trace_checker #(.DEPTH(32), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .exp_val(exp_val), .exp_rdy(exp_rdy), .exp_addr(exp_addr),
    .exp_data(exp_data), .exp_dchk(exp_dchk), .run(run), .trace_addr(trace_addr),
    .trace_inst(trace_inst), .trace_data(trace_data), .trace_stall(trace_stall),
    .addr_W(addr_W), .inst_W(inst_W), .val_W(val_W), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .cycles(cycles), .err(err), .err_addr(err_addr),
    .err_exp(err_exp), .err_got(err_got), .done(done)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    {exp_val, run, trace_stall} = '0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic cyc(input logic r, input logic [31:0] a, input logic s, input logic [31:0] d);
    run = r;
    trace_addr = a;
    trace_inst = {a[15:0], 16'h0093};
    trace_stall = s;
    trace_data = d;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic c);
    exp_val = 1;
    exp_addr = a;
    exp_data = d;
    exp_dchk = c;
    @(posedge clk); #1;
    exp_val = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({val_W, err, pass_cnt, fail_cnt, cycles, addr_W} !== '0) begin
      errs++;
      $display("FAIL reset_zero got val=%b err=%b pass=%0d fail=%0d cyc=%0d exp all 0",
               val_W, err, pass_cnt, fail_cnt, cycles);
    end
    checks++;
    if ({exp_rdy, done} !== 2'b11) begin
      errs++;
      $display("FAIL reset_flags got rdy=%b done=%b exp 1 1", exp_rdy, done);
    end
  endtask

  task automatic test_straight();
    do_reset();
    push(32'h200, 1, 1); push(32'h204, 2, 1); push(32'h208, 3, 1);
    cyc(1, 32'h200, 0, 0); cyc(1, 32'h204, 0, 0); cyc(1, 32'h208, 0, 0); cyc(0, 0, 0, 0);
    chk("straight_val_W", {31'b0, val_W}, 1);
    chk("straight_addr_W", addr_W, 32'h200);
    chk("straight_inst_W", inst_W, 32'h02000093);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 2); cyc(0, 0, 0, 3);
    chk("straight_pass", {16'b0, pass_cnt}, 3);
    chk("straight_fail", {16'b0, fail_cnt}, 0);
    chk("straight_done", {30'b0, err, done}, 1);
    chk("straight_cycles", cycles, 10);
  endtask

  task automatic test_stall();
    do_reset();
    push(32'h200, 1, 1); push(32'h204, 2, 1); push(32'h208, 3, 1);
    cyc(1, 32'h200, 0, 0); cyc(1, 32'h204, 0, 0); cyc(1, 32'h208, 1, 0); cyc(1, 32'h208, 0, 0);
    chk("stall_w0", {val_W, addr_W[30:0]}, {1'b1, 31'h200});
    cyc(0, 0, 0, 1);
    chk("stall_bubble", {31'b0, val_W}, 0);
    cyc(0, 0, 0, 0);
    chk("stall_w1", {val_W, addr_W[30:0]}, {1'b1, 31'h204});
    cyc(0, 0, 0, 2);
    chk("stall_w2", {val_W, addr_W[30:0]}, {1'b1, 31'h208});
    cyc(0, 0, 0, 3);
    chk("stall_pass", {16'b0, pass_cnt}, 3);
    chk("stall_fail", {16'b0, fail_cnt}, 0);
  endtask

  task automatic test_mismatch();
    do_reset();
    push(32'h200, 1, 1); push(32'h204, 5, 1); push(32'h208, 7, 1);
    cyc(1, 32'h200, 0, 0); cyc(1, 32'h204, 0, 0); cyc(1, 32'h208, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 6);
    chk("mm1_fail", {16'b0, fail_cnt}, 1);
    chk("mm1_err_got", err_got, 6);
    cyc(0, 0, 0, 8);
    chk("mm2_fail", {16'b0, fail_cnt}, 2);
    chk("mm2_pass", {16'b0, pass_cnt}, 1);
    chk("mm2_err", {30'b0, err, done}, 2);
    chk("mm2_err_addr", err_addr, 32'h204);
    chk("mm2_err_exp", err_exp, 5);
    chk("mm2_err_got", err_got, 6);
  endtask

  task automatic test_dont_care();
    do_reset();
    push(32'h200, 1, 1); push(32'h204, 0, 0); push(32'h208, 3, 1);
    cyc(1, 32'h200, 0, 0); cyc(1, 32'h204, 0, 0); cyc(1, 32'h208, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 'x);
    chk("dc_pass", {16'b0, pass_cnt}, 2);
    cyc(0, 0, 0, 'x);
    chk("dc_x_fail", {16'b0, fail_cnt}, 1);
    chk("dc_err_addr", err_addr, 32'h208);
    chk("dc_err_exp", err_exp, 3);
  endtask

  task automatic test_fifo_full();
    do_reset();
    for (int i = 0; i < 32; i++) push(32'h1000 + 4 * i, i, 1);
    chk("full_rdy", {31'b0, exp_rdy}, 0);
    cyc(1, 32'h1000, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    exp_val = 1; exp_addr = 32'h9999; exp_data = 0; exp_dchk = 1;
    cyc(0, 0, 0, 0);
    exp_val = 0;
    chk("full_pp_pass", {16'b0, pass_cnt}, 1);
    chk("full_pp_rdy", {31'b0, exp_rdy}, 1);
    push(32'h2000, 0, 1);
    chk("full_refill_rdy", {31'b0, exp_rdy}, 0);
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(1, 32'h300, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 32'h55);
    chk("uf_fail", {16'b0, fail_cnt}, 1);
    chk("uf_pass", {16'b0, pass_cnt}, 0);
    chk("uf_err_exp", err_exp, 0);
    chk("uf_err_addr", err_addr, 32'h300);
    chk("uf_err_got", err_got, 32'h55);
  endtask

  task automatic test_async_reset();
    do_reset();
    push(32'h200, 1, 1); push(32'h204, 2, 1);
    cyc(1, 32'h200, 0, 0); cyc(1, 32'h204, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("ar_pre_pass", {16'b0, pass_cnt}, 1);
    #2 rst = 1;
    #1;
    chk("ar_now_stats", {pass_cnt, fail_cnt}, 0);
    chk("ar_now_cycles", cycles, 0);
    chk("ar_now_w", {val_W, addr_W[30:0]}, 0);
    chk("ar_now_flags", {29'b0, exp_rdy, done, err}, 3'b110);
    #1 rst = 0;
    run = 0; trace_data = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("ar_cycles", cycles, 3);
    chk("ar_pass", {16'b0, pass_cnt}, 0);
    chk("ar_done", {31'b0, done}, 1);
  endtask

  initial begin
    test_reset();
    test_straight();
    test_stall();
    test_mismatch();
    test_dont_care();
    test_fifo_full();
    test_underflow();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
